// File: rtl/adc_supply_fwd_monitor.sv
// rtl/adc_supply_fwd_monitor.sv - boxcar averaging and supply UV/OV monitor for ADC78H90 AIN5/AIN6
//
// Averages AIN5 (forward power) and AIN6 (13.8 V supply) over 2^AVG_SHIFT
// conversion frames. It also raises debounced supply under- and over-voltage
// flags with hysteresis.
//
// Ports:
//   clock       system clock, shared with the ADC reader
//   rst_n       asynchronous active-low reset
//   nCS         reader chip select; rising edge marks fresh AIN5/AIN6
//   AIN5        forward-power volts (valid in the nCS rising-edge cycle)
//   AIN6        supply volts (valid in the nCS rising-edge cycle)
//   clear_peak  synchronous clear of fwd_peak (peak-hold builds only)
//   fwd_avg     averaged AIN5
//   supply_avg  averaged AIN6
//   avg_valid   high during the UPDATE cycle
//                 fwd_avg, supply_avg and the flags take their new values
//                 on the clock that ends this cycle
//   supply_uv   undervoltage flag
//   supply_ov   overvoltage flag
//   fwd_peak    forward peak-hold, or fwd_avg when the peak register is not built
//
// Build option:
//   FWD_PEAK_HOLD_EN  builds the AIN5 peak-hold register behind fwd_peak.

module adc_supply_fwd_monitor #(
    parameter int          AVG_SHIFT = 4,
    parameter logic [11:0] UV_THRESH = 12'd2900,
    parameter logic [11:0] UV_CLEAR  = 12'd3000,
    parameter logic [11:0] OV_THRESH = 12'd3800,
    parameter logic [11:0] OV_CLEAR  = 12'd3700,
    parameter int          FAULT_CNT = 3
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        nCS,
    input  logic [11:0] AIN5,
    input  logic [11:0] AIN6,
    input  logic        clear_peak,
    output logic [11:0] fwd_avg,
    output logic [11:0] supply_avg,
    output logic        avg_valid,
    output logic        supply_uv,
    output logic        supply_ov,
    output logic [11:0] fwd_peak
);

    localparam int                   AW        = 12 + AVG_SHIFT;
    localparam logic [AVG_SHIFT-1:0] CNT_ONE   = AVG_SHIFT'(1);
    localparam logic [3:0]           FAULT_MAX = 4'(FAULT_CNT);

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_UPDATE = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic                 nCS_d;
    logic                 tick;
    logic [AW-1:0]        acc_f, acc_f_nxt;
    logic [AW-1:0]        acc_s, acc_s_nxt;
    logic [AVG_SHIFT-1:0] cnt, cnt_nxt;
    logic [3:0]           uv_cnt, uv_cnt_nxt;
    logic [3:0]           ov_cnt, ov_cnt_nxt;
    logic [11:0]          fwd_avg_nxt, supply_avg_nxt;
    logic                 uv_nxt, ov_nxt;
    logic [11:0]          f_avg, s_avg;
    logic [AW-1:0]        ain5_ext, ain6_ext;

    // The reader updates AIN5/AIN6 on the same edge that raises nCS.
    // The rising edge of nCS is therefore the "new sample" strobe.
    assign tick = nCS & ~nCS_d;

    assign ain5_ext = {{AVG_SHIFT{1'b0}}, AIN5};
    assign ain6_ext = {{AVG_SHIFT{1'b0}}, AIN6};

    // Dividing by 2^AVG_SHIFT is a truncating bit-select of the accumulator.
    assign f_avg = acc_f[AW-1:AVG_SHIFT];
    assign s_avg = acc_s[AW-1:AVG_SHIFT];

    always_comb begin
        state_nxt      = state;
        acc_f_nxt      = acc_f;
        acc_s_nxt      = acc_s;
        cnt_nxt        = cnt;
        uv_cnt_nxt     = uv_cnt;
        ov_cnt_nxt     = ov_cnt;
        fwd_avg_nxt    = fwd_avg;
        supply_avg_nxt = supply_avg;
        uv_nxt         = supply_uv;
        ov_nxt         = supply_ov;
        avg_valid      = 1'b0;

        case (state)
            ST_ACCUM: begin
                if (tick) begin
                    acc_f_nxt = acc_f + ain5_ext;
                    acc_s_nxt = acc_s + ain6_ext;
                    cnt_nxt   = cnt + CNT_ONE;     // wraps to 0 on the last sample
                    if (&cnt) begin
                        state_nxt = ST_UPDATE;
                    end
                end
            end

            ST_UPDATE: begin
                avg_valid      = 1'b1;
                fwd_avg_nxt    = f_avg;
                supply_avg_nxt = s_avg;

                // A sample landing in this cycle starts the next block
                // instead of being dropped.
                if (tick) begin
                    acc_f_nxt = ain5_ext;
                    acc_s_nxt = ain6_ext;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    acc_f_nxt = '0;
                    acc_s_nxt = '0;
                    cnt_nxt   = '0;
                end

                // Undervoltage counts consecutive low averages.
                // Between UV_THRESH and UV_CLEAR the flag holds its value.
                if (s_avg < UV_THRESH) begin
                    if (uv_cnt != FAULT_MAX) begin
                        uv_cnt_nxt = uv_cnt + 4'd1;
                    end
                    if (uv_cnt_nxt == FAULT_MAX) begin
                        uv_nxt = 1'b1;
                    end
                end else begin
                    uv_cnt_nxt = '0;
                    if (s_avg >= UV_CLEAR) begin
                        uv_nxt = 1'b0;
                    end
                end

                // Overvoltage uses the same scheme with the comparisons reversed.
                if (s_avg > OV_THRESH) begin
                    if (ov_cnt != FAULT_MAX) begin
                        ov_cnt_nxt = ov_cnt + 4'd1;
                    end
                    if (ov_cnt_nxt == FAULT_MAX) begin
                        ov_nxt = 1'b1;
                    end
                end else begin
                    ov_cnt_nxt = '0;
                    if (s_avg <= OV_CLEAR) begin
                        ov_nxt = 1'b0;
                    end
                end

                state_nxt = ST_ACCUM;
            end

            default: begin
                state_nxt = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ACCUM;
            nCS_d      <= 1'b1;   // high so a high nCS at release is not an edge
            acc_f      <= '0;
            acc_s      <= '0;
            cnt        <= '0;
            uv_cnt     <= '0;
            ov_cnt     <= '0;
            fwd_avg    <= '0;
            supply_avg <= '0;
            supply_uv  <= 1'b0;
            supply_ov  <= 1'b0;
        end else begin
            state      <= state_nxt;
            nCS_d      <= nCS;
            acc_f      <= acc_f_nxt;
            acc_s      <= acc_s_nxt;
            cnt        <= cnt_nxt;
            uv_cnt     <= uv_cnt_nxt;
            ov_cnt     <= ov_cnt_nxt;
            fwd_avg    <= fwd_avg_nxt;
            supply_avg <= supply_avg_nxt;
            supply_uv  <= uv_nxt;
            supply_ov  <= ov_nxt;
        end
    end

`ifdef FWD_PEAK_HOLD_EN
    logic [11:0] peak_q;

    // When clear and tick coincide, the clear applies first.
    // The register therefore takes the new sample unconditionally.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (tick && (clear_peak || (AIN5 > peak_q))) begin
            peak_q <= AIN5;
        end else if (clear_peak) begin
            peak_q <= '0;
        end
    end

    assign fwd_peak = peak_q;
`else
    logic unused_clear_peak;

    assign unused_clear_peak = clear_peak;
    assign fwd_peak          = fwd_avg;
`endif

endmodule

// File: tb/tb_adc_supply_fwd_monitor.sv
// tb/tb_adc_supply_fwd_monitor.sv - self-checking bench for adc_supply_fwd_monitor

module tb_adc_supply_fwd_monitor;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        nCS;
    logic [11:0] AIN5;
    logic [11:0] AIN6;
    logic        clear_peak;
    logic [11:0] fwd_avg;
    logic [11:0] supply_avg;
    logic        avg_valid;
    logic        supply_uv;
    logic        supply_ov;
    logic [11:0] fwd_peak;

    always #5 clock = ~clock;

    adc_supply_fwd_monitor dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .nCS        (nCS),
        .AIN5       (AIN5),
        .AIN6       (AIN6),
        .clear_peak (clear_peak),
        .fwd_avg    (fwd_avg),
        .supply_avg (supply_avg),
        .avg_valid  (avg_valid),
        .supply_uv  (supply_uv),
        .supply_ov  (supply_ov),
        .fwd_peak   (fwd_peak)
    );

    // One record per 16-sample block.
    // Even and odd samples may differ.
    // Expected values are hand-derived.
    typedef struct {
        logic [11:0] a5e;
        logic [11:0] a5o;
        logic [11:0] a6e;
        logic [11:0] a6o;
        logic [11:0] exp_f;
        logic [11:0] exp_s;
        logic        exp_uv;
        logic        exp_ov;
    } vec_t;

    typedef struct {
        int          id;
        logic [11:0] f;
        logic [11:0] s;
        logic        uv;
        logic        ov;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int id, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s blk=%0d: got %0d expected %0d", name, id, act, req);
        end
    endtask

    task automatic add_vec(input int a5e, input int a5o, input int a6e, input int a6o,
                           input int f, input int s, input int uv, input int ov);
        vec_t v;
        v.a5e    = 12'(a5e);
        v.a5o    = 12'(a5o);
        v.a6e    = 12'(a6e);
        v.a6o    = 12'(a6o);
        v.exp_f  = 12'(f);
        v.exp_s  = 12'(s);
        v.exp_uv = 1'(uv);
        v.exp_ov = 1'(ov);
        vecs.push_back(v);
    endtask

    // One conversion frame, 65 clocks long.
    // nCS rises together with fresh AIN data.
    task automatic send_tick(input logic [11:0] a5, input logic [11:0] a6, input logic clr);
        @(negedge clock);
        nCS = 1'b0;
        repeat (32) @(negedge clock);
        AIN5       = a5;
        AIN6       = a6;
        nCS        = 1'b1;
        clear_peak = clr;
        @(negedge clock);
        clear_peak = 1'b0;
        repeat (31) @(negedge clock);
    endtask

    // The expectation is queued just before the final sample.
    // Any earlier avg_valid therefore finds an empty scoreboard.
    task automatic send_block(input int id, input vec_t v);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            if (k == 15) begin
                e.id = id;
                e.f  = v.exp_f;
                e.s  = v.exp_s;
                e.uv = v.exp_uv;
                e.ov = v.exp_ov;
                sb.push_back(e);
            end
            send_tick((k % 2 == 0) ? v.a5e : v.a5o, (k % 2 == 0) ? v.a6e : v.a6o, 1'b0);
        end
    endtask

    task automatic wait_drain(input int id);
        for (int c = 0; c < 300 && sb.size() != 0; c++) begin
            @(negedge clock);
        end
        check("scoreboard_drain", id, sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input int id);
        check("rst_fwd_avg",    id, int'(fwd_avg),    0);
        check("rst_supply_avg", id, int'(supply_avg), 0);
        check("rst_avg_valid",  id, int'(avg_valid),  0);
        check("rst_supply_uv",  id, int'(supply_uv),  0);
        check("rst_supply_ov",  id, int'(supply_ov),  0);
        check("rst_fwd_peak",   id, int'(fwd_peak),   0);
    endtask

    // Output monitor.
    // avg_valid marks UPDATE; the new values are visible one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (avg_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("avg_valid_unexpected", -1, 1, 0);
                end else begin
                    e = sb.pop_front();
                    @(negedge clock);
                    check("avg_valid_width", e.id, int'(avg_valid),  0);
                    check("fwd_avg",         e.id, int'(fwd_avg),    int'(e.f));
                    check("supply_avg",      e.id, int'(supply_avg), int'(e.s));
                    check("supply_uv",       e.id, int'(supply_uv),  int'(e.uv));
                    check("supply_ov",       e.id, int'(supply_ov),  int'(e.ov));
`ifndef FWD_PEAK_HOLD_EN
                    check("fwd_peak_tracks", e.id, int'(fwd_peak),   int'(e.f));
`endif
                end
            end
        end
    end

    initial begin
        int last_f;

        rst_n      = 1'b0;
        nCS        = 1'b1;
        AIN5       = '0;
        AIN6       = '0;
        clear_peak = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs(100);
        rst_n = 1'b1;

        //       a5e   a5o   a6e   a6o   f     s     uv ov
        // Basic averaging, truncation and full-scale accumulation.
        add_vec(1000, 1000, 3300, 3300, 1000, 3300, 0, 0);
        add_vec(1,    2,    0,    4095, 1,    2047, 0, 0);
        add_vec(4095, 4095, 4095, 4095, 4095, 4095, 0, 0);
        // Undervoltage debounce and hysteresis.
        add_vec(100,  100,  2800, 2800, 100,  2800, 0, 0);
        add_vec(200,  200,  2800, 2800, 200,  2800, 0, 0);
        add_vec(333,  333,  2800, 2800, 333,  2800, 1, 0);
        add_vec(400,  400,  2950, 2950, 400,  2950, 1, 0);
        add_vec(500,  500,  3050, 3050, 500,  3050, 0, 0);
        // Overvoltage: an in-band block resets the count.
        add_vec(600,  600,  3900, 3900, 600,  3900, 0, 0);
        add_vec(700,  700,  3900, 3900, 700,  3900, 0, 0);
        add_vec(800,  800,  3750, 3750, 800,  3750, 0, 0);
        add_vec(900,  900,  3900, 3900, 900,  3900, 0, 0);
        add_vec(901,  901,  3900, 3900, 901,  3900, 0, 0);
        add_vec(902,  902,  3900, 3900, 902,  3900, 0, 1);
        add_vec(903,  903,  3700, 3700, 903,  3700, 0, 0);
        // Undervoltage threshold boundaries.
        add_vec(10,   10,   2899, 2899, 10,   2899, 0, 0);
        add_vec(11,   11,   2899, 2899, 11,   2899, 0, 0);
        add_vec(12,   12,   2900, 2900, 12,   2900, 0, 0);
        add_vec(13,   13,   2899, 2899, 13,   2899, 0, 0);
        add_vec(14,   14,   2899, 2899, 14,   2899, 0, 0);
        add_vec(15,   15,   2899, 2899, 15,   2899, 1, 0);
        add_vec(16,   16,   3000, 3000, 16,   3000, 0, 0);
        // Overvoltage threshold boundaries, including hold inside the band.
        add_vec(20,   20,   3801, 3801, 20,   3801, 0, 0);
        add_vec(21,   21,   3801, 3801, 21,   3801, 0, 0);
        add_vec(22,   22,   3800, 3800, 22,   3800, 0, 0);
        add_vec(23,   23,   3801, 3801, 23,   3801, 0, 0);
        add_vec(24,   24,   3801, 3801, 24,   3801, 0, 0);
        add_vec(25,   25,   3801, 3801, 25,   3801, 0, 1);
        add_vec(26,   26,   3750, 3750, 26,   3750, 0, 1);
        add_vec(27,   27,   3700, 3700, 27,   3700, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            send_block(i, vecs[i]);
        end
        wait_drain(101);
        last_f = 27;

        // Peak hold.
        // Without the register, fwd_peak must stay at the last average.
        @(negedge clock);
        clear_peak = 1'b1;
        @(negedge clock);
        clear_peak = 1'b0;
        @(negedge clock);
`ifdef FWD_PEAK_HOLD_EN
        check("peak_clear", 200, int'(fwd_peak), 0);
`else
        check("peak_clear", 200, int'(fwd_peak), last_f);
`endif
        send_tick(12'd200, 12'd3300, 1'b0);
        send_tick(12'd900, 12'd3300, 1'b0);
        send_tick(12'd300, 12'd3300, 1'b0);
`ifdef FWD_PEAK_HOLD_EN
        check("peak_max", 201, int'(fwd_peak), 900);
`else
        check("peak_max", 201, int'(fwd_peak), last_f);
`endif
        send_tick(12'd100, 12'd3300, 1'b1);
`ifdef FWD_PEAK_HOLD_EN
        check("peak_clear_tick", 202, int'(fwd_peak), 100);
`else
        check("peak_clear_tick", 202, int'(fwd_peak), last_f);
`endif

        // Reset after 8 samples of a block discards the partial sums.
        for (int k = 0; k < 4; k++) begin
            send_tick(12'd4000, 12'd3300, 1'b0);
        end
        @(negedge clock);
        rst_n = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_outputs(300);
        rst_n = 1'b1;
        begin
            vec_t v;
            v.a5e    = 12'd500;
            v.a5o    = 12'd500;
            v.a6e    = 12'd3300;
            v.a6o    = 12'd3300;
            v.exp_f  = 12'd500;
            v.exp_s  = 12'd3300;
            v.exp_uv = 1'b0;
            v.exp_ov = 1'b0;
            send_block(301, v);
        end
        wait_drain(302);
        repeat (5) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
